ahb_arbiter: RTL



---
 rtl/ahb_arbiter_if.sv | 31 +++
 rtl/ahb_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// Bundle of AHB arbitration signals shared between the arbiter and the
// requesting masters / bus mux.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic [2:0]             Hburst;
  logic                   Hready;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MW-1:0]          Hmaster;
  logic [MW-1:0]          Hmaster_data;
  logic                   Hmastlock;
  // arbitration state view: 0=PARK 1=OWN 2=BURST 3=LOCKED
  logic [1:0]             Hstate;

  // arbiter side
  modport master (
    input  Hbusreq, Hlock, Htrans, Hburst, Hready,
    output Hgrant, Hmaster, Hmaster_data, Hmastlock, Hstate
  );

  // requesting masters / bus mux side
  modport slave (
    output Hbusreq, Hlock, Htrans, Hburst, Hready,
    input  Hgrant, Hmaster, Hmaster_data, Hmastlock, Hstate
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst- and lock-aware handover on Hready
// transfer boundaries. Hmaster selects the address phase, Hmaster_data the
// write-data/response phase one completed transfer later.
//
// state  | meaning
// PARK   | no requests, default master parked on the bus
// OWN    | owner may be rearbitrated at the next boundary
// BURST  | fixed-length burst in progress (burst_rem > 0)
// LOCKED | locked sequence in progress, no handover
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic          Hclk,
  input  logic          Hreset,
  ahb_arbiter_if.master bus
);

  localparam int            MW  = $clog2(NUM_MASTERS);
  localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    BURST  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        r_state;
  logic [MW-1:0] r_hmaster;
  logic [MW-1:0] r_hmaster_data;
  logic          r_mastlock;
  logic [4:0]    r_burst_rem;

  logic          w_fixed_nonseq;
  logic          w_lock_hold;
  logic          w_arb_ok;
  logic          w_found;
  logic [MW-1:0] w_winner;
  logic [MW-1:0] w_next_owner;
  logic [4:0]    w_burst_nxt;
  state_t        w_state_nxt;

  // Handover permission. A fixed-length NONSEQ commits its master to the
  // whole burst, so the first beat is never a handover point either.
  always_comb begin
    w_fixed_nonseq = (bus.Htrans == TR_NONSEQ) && (bus.Hburst[2:1] != 2'b00);
    w_lock_hold    = bus.Hlock[r_hmaster] | r_mastlock;
    w_arb_ok       = !w_lock_hold && !w_fixed_nonseq &&
                     ((r_burst_rem == 5'd0) ||
                      ((r_burst_rem == 5'd1) && (bus.Htrans == TR_SEQ)));
  end

  // Round-robin search from Hmaster+1, current owner checked last, park if idle.
  always_comb begin
    w_found  = 1'b0;
    w_winner = DEF;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int idx;
      idx = (int'(r_hmaster) + i) % NUM_MASTERS;
      if (!w_found && bus.Hbusreq[idx]) begin
        w_found  = 1'b1;
        w_winner = idx[MW-1:0];
      end
    end
    w_next_owner = w_arb_ok ? w_winner : r_hmaster;
  end

  // Beats remaining in a fixed-length burst after the current transfer.
  always_comb begin
    w_burst_nxt = r_burst_rem;
    if (bus.Htrans == TR_NONSEQ) begin
      case (bus.Hburst)
        3'b010, 3'b011: w_burst_nxt = 5'd3;
        3'b100, 3'b101: w_burst_nxt = 5'd7;
        3'b110, 3'b111: w_burst_nxt = 5'd15;
        default:        w_burst_nxt = 5'd0;
      endcase
    end else if ((bus.Htrans == TR_SEQ) && (r_burst_rem != 5'd0)) begin
      w_burst_nxt = r_burst_rem - 5'd1;
    end
  end

  // State view after the coming boundary.
  always_comb begin
    if (bus.Hlock[w_next_owner])     w_state_nxt = LOCKED;
    else if (w_burst_nxt != 5'd0)    w_state_nxt = BURST;
    else if (bus.Hbusreq == '0)      w_state_nxt = PARK;
    else                             w_state_nxt = OWN;
  end

  // All arbitration state advances only on completed transfers.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state        <= PARK;
      r_hmaster      <= DEF;
      r_hmaster_data <= DEF;
      r_mastlock     <= 1'b0;
      r_burst_rem    <= 5'd0;
    end else if (bus.Hready) begin
      r_state        <= w_state_nxt;
      r_hmaster      <= w_next_owner;
      r_hmaster_data <= r_hmaster;
      r_mastlock     <= bus.Hlock[w_next_owner];
      r_burst_rem    <= w_burst_nxt;
    end
  end

  assign bus.Hgrant       = NUM_MASTERS'(1) << w_next_owner;
  assign bus.Hmaster      = r_hmaster;
  assign bus.Hmaster_data = r_hmaster_data;
  assign bus.Hmastlock    = r_mastlock;
  assign bus.Hstate       = r_state;

endmodule
